wifi_tx_frame_ctrl: RTL and testbench

Frame-level sequencer for the WIFI TX OFDM path. Sits between the constellation mapper and the OFDM block: it accepts a symbol count and a start command from the register interface, gates mapper samples into the OFDM block symbol by symbol, and flags the final symbol. It then waits for the OFDM block to report completion, with a watchdog, and raises a maskable TX-done interrupt.

---
 rtl/wifi_tx_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_wifi_tx_frame_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wifi_tx_frame_ctrl.sv
// Frame sequencer between constellation mapper and OFDM block: gates SYM_LEN-sample symbols, flags the final symbol, raises TX-done irq.
// Latency: accepted mapper sample appears on ofdm_* one cycle later; DONE follows ofdm_finished by one cycle.
// Backpressure: src_ready is high only while streaming; mapper bubbles hold all counters, no stall from the OFDM side.
module wifi_tx_frame_ctrl #(
   parameter int SYM_LEN = 48,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 4095
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_sym,
   input  logic             abort,
   input  logic             src_valid,
   input  logic [11:0]      src_re,
   input  logic [11:0]      src_im,
   output logic             src_ready,
   output logic             ofdm_valid,
   output logic [11:0]      ofdm_re,
   output logic [11:0]      ofdm_im,
   output logic             ofdm_last_sym,
   input  logic             ofdm_finished,
   output logic             busy,
   input  logic             irq_en,
   input  logic             irq_clear,
   output logic             tx_irq,
   output logic             err
);

   localparam int SAMP_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
   localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SYM_LEN - 1);
   localparam logic [SAMP_W-1:0] SAMP_ONE  = SAMP_W'(1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);
   localparam logic [CNT_W-1:0]  SYM_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [11:0] re;
      logic [11:0] im;
   } samp_t;

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    num_sym_q;
   logic [CNT_W-1:0]    sym_cnt_q;
   logic [SAMP_W-1:0]   samp_cnt_q;
   logic [WD_W-1:0]     wd_cnt_q;
   logic                irq_flag_q;
   logic                err_q;
   samp_t               out_q;
   logic                out_vld_q;
   logic                out_last_q;

   logic                start_ok;
   logic                start_zero;
   logic                accept;
   logic                samp_wrap;
   logic                on_last_sym;
   logic                frame_end;
   logic                wd_expire;
   logic                done_set;
   logic                abort_act;

   always_comb begin
      start_zero  = (state_q == ST_IDLE) && start && (num_sym == '0);
      start_ok    = (state_q == ST_IDLE) && start && (num_sym != '0);
      abort_act   = abort && (state_q != ST_IDLE);
      accept      = (state_q == ST_STREAM) && src_valid && !abort;
      samp_wrap   = (samp_cnt_q == SAMP_LAST);
      on_last_sym = (sym_cnt_q == (num_sym_q - SYM_ONE));
      frame_end   = accept && samp_wrap && on_last_sym;
      // finished takes priority over an expiring watchdog in the same cycle
      wd_expire   = (state_q == ST_DRAIN) && !ofdm_finished && !abort && (wd_cnt_q == WD_LAST);
      done_set    = (state_q == ST_DONE) && !abort;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (abort)          state_d = ST_IDLE;
            else if (frame_end) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (abort)                         state_d = ST_IDLE;
            else if (ofdm_finished || wd_expire) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         num_sym_q  <= '0;
         sym_cnt_q  <= '0;
         samp_cnt_q <= '0;
      end else if (start_ok) begin
         num_sym_q  <= num_sym;
         sym_cnt_q  <= '0;
         samp_cnt_q <= '0;
      end else if (abort_act) begin
         sym_cnt_q  <= '0;
         samp_cnt_q <= '0;
      end else if (accept) begin
         if (samp_wrap) begin
            samp_cnt_q <= '0;
            if (sym_cnt_q != '1) sym_cnt_q <= sym_cnt_q + SYM_ONE;
         end else begin
            samp_cnt_q <= samp_cnt_q + SAMP_ONE;
         end
      end
   end

   // watchdog runs only in DRAIN and saturates at its terminal value
   always_ff @(posedge clk) begin
      if (!reset) begin
         wd_cnt_q <= '0;
      end else if (state_q != ST_DRAIN || abort) begin
         wd_cnt_q <= '0;
      end else if (wd_cnt_q != WD_LAST) begin
         wd_cnt_q <= wd_cnt_q + WD_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
      end else begin
         out_vld_q  <= accept;
         out_last_q <= accept && on_last_sym;
         if (accept) out_q <= '{re: src_re, im: src_im};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         irq_flag_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (done_set)       irq_flag_q <= 1'b1;
         else if (irq_clear) irq_flag_q <= 1'b0;

         if (start_zero || wd_expire)  err_q <= 1'b1;
         else if (start_ok || irq_clear) err_q <= 1'b0;
      end
   end

   assign src_ready     = (state_q == ST_STREAM);
   assign busy          = (state_q != ST_IDLE);
   assign ofdm_valid    = out_vld_q;
   assign ofdm_re       = out_q.re;
   assign ofdm_im       = out_q.im;
   assign ofdm_last_sym = out_last_q;
   assign tx_irq        = irq_flag_q && irq_en;
   assign err           = err_q;

endmodule

// File: tb/tb_wifi_tx_frame_ctrl.sv
// Bench for wifi_tx_frame_ctrl: directed frames checked every cycle against a
// sample-counting frame model, plus literal expectations per scenario.
module tb_wifi_tx_frame_ctrl;

   localparam int SYM_LEN = 48;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_sym = '0;
   logic             abort = 1'b0;
   logic             src_valid = 1'b0;
   logic [11:0]      src_re = '0;
   logic [11:0]      src_im = '0;
   logic             src_ready;
   logic             ofdm_valid;
   logic [11:0]      ofdm_re;
   logic [11:0]      ofdm_im;
   logic             ofdm_last_sym;
   logic             ofdm_finished = 1'b0;
   logic             busy;
   logic             irq_en = 1'b0;
   logic             irq_clear = 1'b0;
   logic             tx_irq;
   logic             err;

   wifi_tx_frame_ctrl #(.SYM_LEN(SYM_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .num_sym(num_sym), .abort(abort),
      .src_valid(src_valid), .src_re(src_re), .src_im(src_im), .src_ready(src_ready),
      .ofdm_valid(ofdm_valid), .ofdm_re(ofdm_re), .ofdm_im(ofdm_im),
      .ofdm_last_sym(ofdm_last_sym), .ofdm_finished(ofdm_finished), .busy(busy),
      .irq_en(irq_en), .irq_clear(irq_clear), .tx_irq(tx_irq), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Frame model: phase 0 idle, 1 streaming, 2 waiting for finish, 3 done.
   // Tracks the frame as a total sample budget rather than symbol/sample counters.
   int   m_phase = 0;
   int   m_n = 0;
   int   m_k = 0;
   int   m_wait = 0;
   bit   m_irq = 0;
   bit   m_err = 0;
   bit   e_valid = 0;
   bit   e_last = 0;
   int   e_re = 0;
   int   e_im = 0;
   bit   cmp_en = 0;
   bit   acc, done_evt, err_set, err_clr;

   always @(posedge clk) begin
      if (!reset) begin
         m_phase = 0; m_n = 0; m_k = 0; m_wait = 0;
         m_irq = 0; m_err = 0; e_valid = 0; e_last = 0; e_re = 0; e_im = 0;
      end else begin
         acc      = (m_phase == 1) && src_valid && !abort;
         done_evt = (m_phase == 3) && !abort;
         err_set  = 0;
         err_clr  = irq_clear;
         e_valid  = acc;
         e_last   = acc && (m_k >= m_n - SYM_LEN);
         if (acc) begin
            e_re = int'(src_re);
            e_im = int'(src_im);
         end
         case (m_phase)
            0: if (start) begin
                  if (num_sym == 0) err_set = 1;
                  else begin
                     m_phase = 1; m_n = int'(num_sym) * SYM_LEN; m_k = 0; err_clr = 1;
                  end
               end
            1: if (abort) m_phase = 0;
               else if (acc) begin
                  m_k++;
                  if (m_k == m_n) begin m_phase = 2; m_wait = 0; end
               end
            2: if (abort) m_phase = 0;
               else if (ofdm_finished) m_phase = 3;
               else begin
                  m_wait++;
                  if (m_wait >= TIMEOUT) begin m_phase = 3; err_set = 1; end
               end
            default: m_phase = 0;
         endcase
         if (done_evt) m_irq = 1;
         else if (irq_clear) m_irq = 0;
         if (err_set) m_err = 1;
         else if (err_clr) m_err = 0;
      end
      cmp_en = 1;
   end

   int v_cnt = 0;
   int l_cnt = 0;
   int first_last = -1;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk1("src_ready", src_ready, m_phase == 1);
         chk1("busy", busy, m_phase != 0);
         chk1("ofdm_valid", ofdm_valid, e_valid);
         chk1("ofdm_last_sym", ofdm_last_sym, e_last);
         chk1("tx_irq", tx_irq, m_irq && irq_en);
         chk1("err", err, m_err);
         if (e_valid) begin
            chkn("ofdm_re", int'(ofdm_re), e_re);
            chkn("ofdm_im", int'(ofdm_im), e_im);
         end
         if (ofdm_valid === 1'b1) begin
            if (ofdm_last_sym === 1'b1) begin
               if (first_last < 0) first_last = v_cnt;
               l_cnt++;
            end
            v_cnt++;
         end
      end
   end

   int dseq = 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_counts();
      v_cnt = 0; l_cnt = 0; first_last = -1;
   endtask

   task automatic drive_data();
      src_re = 12'((dseq * 7 + 1) & 32'hFFF);
      src_im = 12'((dseq * 13 + 100) & 32'hFFF);
      dseq++;
   endtask

   task automatic start_frame(input int n);
      num_sym = CNT_W'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic stream_to_drain(input int max_cyc);
      int n = 0;
      src_valid = 1'b1;
      while (src_ready && n < max_cyc) begin
         drive_data();
         tick();
         n++;
      end
      src_valid = 1'b0;
      chk1("drain_reached", busy && !src_ready, 1'b1);
   endtask

   task automatic finish_pulse();
      ofdm_finished = 1'b1;
      tick();
      ofdm_finished = 1'b0;
      tick();
   endtask

   task automatic clear_irq();
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      tick(); tick();
      chk1("rst_src_ready", src_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_valid", ofdm_valid, 1'b0);
      chkn("rst_re", int'(ofdm_re), 0);
      chkn("rst_im", int'(ofdm_im), 0);
      chk1("rst_last", ofdm_last_sym, 1'b0);
      chk1("rst_irq", tx_irq, 1'b0);
      chk1("rst_err", err, 1'b0);
      reset = 1'b1;
      irq_en = 1'b1;
      tick();

      // nominal three-symbol frame, finished 10 cycles into DRAIN
      clr_counts();
      start_frame(3);
      chk1("nom_busy", busy, 1'b1);
      stream_to_drain(400);
      repeat (9) tick();
      finish_pulse();
      chkn("nom_valid_cnt", v_cnt, 144);
      chkn("nom_last_cnt", l_cnt, 48);
      chkn("nom_first_last", first_last, 96);
      chk1("nom_irq", tx_irq, 1'b1);
      chk1("nom_err", err, 1'b0);
      chk1("nom_busy_end", busy, 1'b0);
      clear_irq();
      chk1("nom_irq_cleared", tx_irq, 1'b0);

      // bubbles every other cycle
      clr_counts();
      start_frame(1);
      for (int i = 0; i < 96; i++) begin
         src_valid = (i % 2 == 0);
         drive_data();
         tick();
      end
      src_valid = 1'b0;
      chkn("bub_valid_cnt", v_cnt, 48);
      chkn("bub_last_cnt", l_cnt, 48);
      chk1("bub_drain", busy && !src_ready, 1'b1);
      finish_pulse();
      clear_irq();

      // watchdog timeout
      clr_counts();
      start_frame(1);
      stream_to_drain(100);
      repeat (15) tick();
      chk1("to_err_pre", err, 1'b0);
      chk1("to_busy_pre", busy, 1'b1);
      tick();
      chk1("to_err_done", err, 1'b1);
      tick();
      chk1("to_busy_end", busy, 1'b0);
      chk1("to_irq", tx_irq, 1'b1);
      chk1("to_err_sticky", err, 1'b1);
      start_frame(1);
      chk1("to_err_cleared", err, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      clear_irq();

      // zero-length start, then start while streaming
      start_frame(0);
      chk1("zero_err", err, 1'b1);
      chk1("zero_busy", busy, 1'b0);
      chk1("zero_irq", tx_irq, 1'b0);
      clr_counts();
      start_frame(1);
      chk1("bs_err_clr", err, 1'b0);
      src_valid = 1'b1;
      repeat (10) begin drive_data(); tick(); end
      num_sym = CNT_W'(5);
      start = 1'b1;
      drive_data();
      tick();
      start = 1'b0;
      stream_to_drain(300);
      finish_pulse();
      chkn("bs_len", v_cnt, 48);
      clear_irq();

      // abort mid-frame, then a clean frame
      clr_counts();
      start_frame(2);
      src_valid = 1'b1;
      repeat (50) begin drive_data(); tick(); end
      abort = 1'b1;
      drive_data();
      tick();
      abort = 1'b0;
      src_valid = 1'b0;
      chk1("ab_busy", busy, 1'b0);
      chk1("ab_valid", ofdm_valid, 1'b0);
      chk1("ab_ready", src_ready, 1'b0);
      tick(); tick();
      chk1("ab_irq", tx_irq, 1'b0);
      chkn("ab_cnt", v_cnt, 50);
      clr_counts();
      start_frame(1);
      stream_to_drain(100);
      finish_pulse();
      chkn("ab_clean_cnt", v_cnt, 48);
      chk1("ab_clean_irq", tx_irq, 1'b1);
      chk1("ab_clean_err", err, 1'b0);
      clear_irq();

      // irq_clear coincident with DONE, then irq_en gating
      start_frame(1);
      stream_to_drain(100);
      ofdm_finished = 1'b1;
      tick();
      ofdm_finished = 1'b0;
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;
      chk1("race_irq", tx_irq, 1'b1);
      irq_en = 1'b0;
      #1;
      chk1("mask_irq", tx_irq, 1'b0);
      irq_en = 1'b1;
      #1;
      chk1("unmask_irq", tx_irq, 1'b1);

      // synchronous reset mid-stream with irq flag still pending
      start_frame(2);
      src_valid = 1'b1;
      repeat (20) begin drive_data(); tick(); end
      reset = 1'b0;
      tick();
      chk1("mrst_ready", src_ready, 1'b0);
      chk1("mrst_valid", ofdm_valid, 1'b0);
      chkn("mrst_re", int'(ofdm_re), 0);
      chkn("mrst_im", int'(ofdm_im), 0);
      chk1("mrst_last", ofdm_last_sym, 1'b0);
      chk1("mrst_busy", busy, 1'b0);
      chk1("mrst_irq", tx_irq, 1'b0);
      chk1("mrst_err", err, 1'b0);
      src_valid = 1'b0;
      reset = 1'b1;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
